// File: rtl/soc_bus_mem.sv
// rtl/soc_bus_mem.sv - byte-writable RAM plus LED/UART IO page on the mem_* bus
// RAM reads are registered and read-before-write; the IO page decodes mem_addr[3:2].
module soc_bus_mem #(
   parameter int    NWORDS    = 256,
   parameter string INIT_FILE = "",
   parameter int    IO_BIT    = 22,
   parameter int    LED_WIDTH = 5,
   parameter int    BAUD_DIV  = 104
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [31:0]          mem_addr,
   input  logic                 mem_rstrb,
   output logic [31:0]          mem_rdata,
   input  logic [31:0]          mem_wdata,
   input  logic [3:0]           mem_wmask,
   output logic [LED_WIDTH-1:0] leds,
   output logic                 txd
);
   localparam int AW = $clog2(NWORDS);
   localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   logic [31:0]   ram [NWORDS];
   logic          is_io;
   logic [AW-1:0] word_idx;
   logic [1:0]    reg_idx;
   logic          busy;
   logic          unused_addr;

   state_t        state, state_n;
   logic [9:0]    shift, shift_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [BW-1:0] baud_cnt, baud_cnt_n;
   logic          uart_wr;
   logic          last_tick;

   assign is_io       = mem_addr[IO_BIT];
   assign word_idx    = mem_addr[2 +: AW];
   assign reg_idx     = mem_addr[3:2];
   assign unused_addr = ^mem_addr;

   // No reset on the array so it maps onto block RAM and survives resetn.
   always_ff @(posedge clk) begin
      if (resetn && !is_io) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_wmask[i]) ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_rdata <= 32'd0;
         leds      <= '0;
      end else begin
         if (mem_rstrb) begin
            if (is_io) begin
               case (reg_idx)
                  2'd0:    mem_rdata <= {{(32-LED_WIDTH){1'b0}}, leds};
                  2'd2:    mem_rdata <= {31'd0, busy};
                  default: mem_rdata <= 32'd0;
               endcase
            end else begin
               mem_rdata <= ram[word_idx];
            end
         end
         if (is_io && reg_idx == 2'd0 && mem_wmask[0]) leds <= mem_wdata[LED_WIDTH-1:0];
      end
   end

   assign uart_wr   = is_io && reg_idx == 2'd1 && mem_wmask[0];
   assign last_tick = state == SEND && baud_cnt == '0 && bit_cnt == 4'd1;
   assign busy      = state == SEND;
   assign txd       = busy ? shift[0] : 1'b1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         shift    <= '1;
         bit_cnt  <= 4'd0;
         baud_cnt <= '0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         bit_cnt  <= bit_cnt_n;
         baud_cnt <= baud_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      shift_n    = shift;
      bit_cnt_n  = bit_cnt;
      baud_cnt_n = baud_cnt;
      case (state)
         IDLE: ;
         SEND: begin
            if (baud_cnt == '0) begin
               baud_cnt_n = BW'(BAUD_DIV - 1);
               shift_n    = {1'b1, shift[9:1]};
               bit_cnt_n  = bit_cnt - 4'd1;
               if (bit_cnt == 4'd1) state_n = IDLE;
            end else begin
               baud_cnt_n = baud_cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // The edge that ends a frame can already accept the next byte.
      if (uart_wr && (state == IDLE || last_tick)) begin
         state_n    = SEND;
         shift_n    = {1'b1, mem_wdata[7:0], 1'b0};
         bit_cnt_n  = 4'd10;
         baud_cnt_n = BW'(BAUD_DIV - 1);
      end
   end
endmodule
